prog_loader: RTL and testbench

- Write-side counterpart of the instruction ROM read path.
- Accepts a byte stream over a valid/ready handshake and packs every 3 bytes into one 24-bit instruction word ({opcode[7:0], operand[15:0]}).
- Writes each word into the program memory write port at consecutive addresses.
- Holds the CPU in reset while a load is in progress, so a new program can be written without resynthesising the ROM contents.

---
 rtl/prog_loader_pkg.sv | 25 ++
 rtl/prog_loader_asm.sv | 55 +++++
 rtl/prog_loader.sv | 181 ++++++++++++++++++
 tb/tb_prog_loader.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM states, word geometry and byte lanes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Byte lanes follow the instruction layout {opcode[7:0], operand[15:0]}; the stream
// delivers the opcode byte first, then the operand high byte, then the operand low byte.
package prog_loader_pkg;

  localparam int BYTES_PER_WORD = 3;
  localparam int WORD_BITS      = BYTES_PER_WORD * 8;

  // Bit position of each stream byte inside the assembled word.
  localparam int OPCODE_LSB     = 16;  // byte0 -> word[23:16]
  localparam int OPERAND_HI_LSB = 8;   // byte1 -> word[15:8]
  localparam int OPERAND_LO_LSB = 0;   // byte2 -> word[7:0]

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHK   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/prog_loader_asm.sv
// Packs three stream bytes (MSB first) into one instruction word using a 2-bit lane counter.
// Latency: a byte shifted in is visible on word the following cycle.
// Backpressure: none; the caller only asserts shift when a byte is actually accepted.
//
// Ports: clk, rst_n (sync, active low), clr (restart at byte0), shift (accept in_data),
//        in_data (stream byte), word (assembled word), full (this shift completes the word).
module prog_loader_asm
  import prog_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 shift,
  input  logic [7:0]           in_data,
  output logic [WORD_BITS-1:0] word,
  output logic                 full
);

  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

  logic [WORD_BITS-1:0] word_q, word_d;
  logic [1:0]           lane_q, lane_d;

  always_comb begin
    word_d = word_q;
    lane_d = lane_q;
    if (clr) begin
      word_d = '0;
      lane_d = '0;
    end else if (shift) begin
      case (lane_q)
        2'd0:    word_d[OPCODE_LSB +: 8]     = in_data;
        2'd1:    word_d[OPERAND_HI_LSB +: 8] = in_data;
        2'd2:    word_d[OPERAND_LO_LSB +: 8] = in_data;
        default: ;
      endcase
      lane_d = (lane_q == LAST_LANE) ? 2'd0 : lane_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q <= '0;
      lane_q <= '0;
    end else begin
      word_q <= word_d;
      lane_q <= lane_d;
    end
  end

  assign word = word_q;
  // Combinational so the FSM can leave RECV on the same edge that captures byte2.
  assign full = shift && !clr && (lane_q == LAST_LANE);

endmodule

// File: rtl/prog_loader.sv
// Loads a byte stream into program memory as 24-bit words at consecutive addresses, holding the CPU in reset meanwhile.
// Latency: 3 accept cycles + 1 write cycle per word; done pulses the cycle after the last write (after CHK if enabled).
// Backpressure: in_ready is high only in RECV (and CHK); the stream must hold a byte until in_valid && in_ready.
//
// Optional feature macro: PROG_LOADER_CHECKSUM_EN (trailing checksum byte, err flag).
// Ports: clk, rst_n (sync, active low); start/base_addr/word_count request a load; abort cancels it;
//        in_data/in_valid/in_ready byte stream; mem_we/mem_addr/mem_wdata memory write port;
//        busy/cpu_hold load in progress; done completion pulse; err checksum mismatch (sticky).
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int RAM_WORD_WIDTH = WORD_BITS,
  parameter int RAM_ADDR_BITS  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [RAM_ADDR_BITS-1:0]  base_addr,
  input  logic [RAM_ADDR_BITS:0]    word_count,
  input  logic                      abort,
  input  logic [7:0]                in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      mem_we,
  output logic [RAM_ADDR_BITS-1:0]  mem_addr,
  output logic [RAM_WORD_WIDTH-1:0] mem_wdata,
  output logic                      busy,
  output logic                      cpu_hold,
  output logic                      done,
  output logic                      err
);

  localparam logic [RAM_ADDR_BITS-1:0] ADDR_ONE = 1;
  localparam logic [RAM_ADDR_BITS:0]   REM_ONE  = 1;

  state_e                    state_q, state_d;
  logic [RAM_ADDR_BITS-1:0]  addr_q, addr_d;
  logic [RAM_ADDR_BITS:0]    rem_q, rem_d;
  logic [RAM_ADDR_BITS-1:0]  mem_addr_q, mem_addr_d;
  logic [RAM_WORD_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]                sum_q, sum_d;
  logic                      err_q, err_d;
`endif

  logic                      asm_clr;
  logic                      asm_shift;
  logic [WORD_BITS-1:0]      asm_word;
  logic                      asm_full;

  prog_loader_asm u_asm (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (asm_clr),
    .shift   (asm_shift),
    .in_data (in_data),
    .word    (asm_word),
    .full    (asm_full)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    asm_clr     = 1'b0;
    asm_shift   = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
    err_d       = err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          asm_clr = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d   = '0;
          err_d   = 1'b0;
`endif
          if (word_count != '0) begin
            addr_d  = base_addr;
            rem_d   = word_count;
            state_d = ST_RECV;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_RECV: begin
        // Abort wins over a byte offered in the same cycle; the partial word is dropped.
        if (abort) begin
          asm_clr = 1'b1;
          state_d = ST_IDLE;
        end else if (in_valid) begin
          asm_shift = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d     = sum_q + in_data;
`endif
          if (asm_full) begin
            state_d = ST_WRITE;
          end
        end
      end

      ST_WRITE: begin
        // Capture what is being written so the port holds it once we leave WRITE.
        mem_addr_d  = addr_q;
        mem_wdata_d = asm_word;
        addr_d      = addr_q + ADDR_ONE;
        rem_d       = rem_q - REM_ONE;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (rem_q == REM_ONE) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_d = ST_CHK;
`else
          state_d = ST_DONE;
`endif
        end else begin
          state_d = ST_RECV;
        end
      end

`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (in_valid) begin
          err_d   = (in_data != sum_q);
          state_d = ST_DONE;
        end
      end
`endif

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
      err_q       <= err_d;
`endif
    end
  end

  assign mem_we    = (state_q == ST_WRITE);
  assign mem_addr  = mem_we ? addr_q : mem_addr_q;
  assign mem_wdata = mem_we ? asm_word : mem_wdata_q;
  assign in_ready  = (state_q == ST_RECV) || (state_q == ST_CHK);
  assign busy      = (state_q == ST_RECV) || (state_q == ST_WRITE) || (state_q == ST_CHK);
  assign cpu_hold  = busy;
  assign done      = (state_q == ST_DONE);
`ifdef PROG_LOADER_CHECKSUM_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed and randomized loads against a stream-level model.
// Latency: n/a.
// Backpressure: the byte driver only advances when in_valid && in_ready in the same cycle.
module tb_prog_loader;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam int CHK_CYC = 1;
`else
  localparam int CHK_CYC = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [8:0]  word_count = '0;
  logic        abort = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, mem_we, busy, cpu_hold, done, err;
  logic [7:0]  mem_addr;
  logic [23:0] mem_wdata;

  prog_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .abort(abort), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Observation log, filled at the falling edge.
  int          cyc = 0;
  logic [7:0]  w_addr[$];
  logic [23:0] w_data[$];
  int          w_cyc[$];
  int          busy_cnt = 0, done_cnt = 0, last_done_cyc = 0, rdy_in_write = 0, hold_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      w_addr.push_back(mem_addr);
      w_data.push_back(mem_wdata);
      w_cyc.push_back(cyc);
      if (in_ready) rdy_in_write <= rdy_in_write + 1;
    end
    if (busy) busy_cnt <= busy_cnt + 1;
    if (cpu_hold !== busy) hold_bad <= hold_bad + 1;
    if (done) begin
      done_cnt      <= done_cnt + 1;
      last_done_cyc <= cyc;
    end
  end

  // Stream payload for the next load (data bytes, plus trailing checksum when enabled).
  logic [7:0] tx[$];

  // Reference model: word w of a load is bytes 3w..3w+2 MSB first, at (base + w) mod 256.
  function automatic logic [23:0] model_word(int w);
    return {tx[3*w], tx[3*w+1], tx[3*w+2]};
  endfunction

  function automatic logic [7:0] model_addr(logic [7:0] base, int w);
    return 8'((int'(base) + w) % 256);
  endfunction

  function automatic logic [7:0] model_sum(int nbytes);
    int s = 0;
    for (int i = 0; i < nbytes; i++) s = s + int'(tx[i]);
    return 8'(s % 256);
  endfunction

  task automatic make_tx(input int nwords);
    tx.delete();
    for (int i = 0; i < 3 * nwords; i++) tx.push_back(8'($urandom));
  endtask

  task automatic add_cks();
`ifdef PROG_LOADER_CHECKSUM_EN
    tx.push_back(model_sum(tx.size()));
`endif
  endtask

  // mode 0: valid always high, 1: toggles every cycle, 2: random.
  task automatic drive_load(input logic [7:0] base, input logic [8:0] wc, input int mode,
                            output bit ok, output int start_cyc);
    int  idx = 0;
    int  guard = 0;
    bit  tog = 1'b1;
    bit  v;
    int  d0 = done_cnt;
    ok = 1'b1;
    @(negedge clk);
    start = 1'b1; base_addr = base; word_count = wc; start_cyc = cyc;
    forever begin
      @(negedge clk);
      start = 1'b0;
      if (idx >= tx.size()) break;
      guard++;
      if (guard > 3000) begin ok = 1'b0; break; end
      v = (mode == 0) ? 1'b1 : (mode == 1) ? tog : ($urandom_range(0, 1) == 1);
      tog = !tog;
      in_valid = v;
      in_data  = v ? tx[idx] : 8'($urandom);
      if (v && in_ready) idx++;
    end
    in_valid = 1'b0;
    guard = 0;
    while (done_cnt == d0 && guard < 200) begin @(posedge clk); guard++; end
    if (done_cnt == d0) ok = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    checks++; if (mem_we !== 1'b0)    begin errors++; $display("FAIL reset_mem_we got=%b want=0", mem_we); end
    checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL reset_mem_addr got=%h want=00", mem_addr); end
    checks++; if (mem_wdata !== 24'h0) begin errors++; $display("FAIL reset_mem_wdata got=%h want=000000", mem_wdata); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (cpu_hold !== 1'b0)  begin errors++; $display("FAIL reset_cpu_hold got=%b want=0", cpu_hold); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (err !== 1'b0)       begin errors++; $display("FAIL reset_err got=%b want=0", err); end
  endtask

  // Directed two-word load; mode 0 = continuous valid, mode 1 = toggling valid.
  task automatic test_basic(input int mode);
    bit ok; int sc;
    int w0 = w_addr.size(), b0 = busy_cnt, d0 = done_cnt, r0 = rdy_in_write;
    logic [7:0]  ea[2] = '{8'h10, 8'h11};
    logic [23:0] ed[2] = '{24'h010005, 24'h02000C};
    tx = '{8'h01, 8'h00, 8'h05, 8'h02, 8'h00, 8'h0C};
    add_cks();
    drive_load(8'h10, 9'd2, mode, ok, sc);
    checks++; if (!ok) begin errors++; $display("FAIL basic%0d_timeout got=no_done want=done", mode); end
    checks++; if (w_addr.size() - w0 !== 2) begin errors++; $display("FAIL basic%0d_nwrites got=%0d want=2", mode, w_addr.size() - w0); end
    for (int w = 0; w < 2; w++) begin
      logic [7:0]  ga = (w0 + w < w_addr.size()) ? w_addr[w0 + w] : 8'hxx;
      logic [23:0] gd = (w0 + w < w_data.size()) ? w_data[w0 + w] : 24'hxxxxxx;
      checks++; if (ga !== ea[w]) begin errors++; $display("FAIL basic%0d_addr%0d got=%h want=%h", mode, w, ga, ea[w]); end
      checks++; if (gd !== ed[w]) begin errors++; $display("FAIL basic%0d_data%0d got=%h want=%h", mode, w, gd, ed[w]); end
    end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL basic%0d_done_pulses got=%0d want=1", mode, done_cnt - d0); end
    checks++; if (rdy_in_write !== r0) begin errors++; $display("FAIL basic%0d_ready_in_write got=%0d want=0", mode, rdy_in_write - r0); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic%0d_err got=%b want=0", mode, err); end
    if (mode == 0) begin
      int ld = (w_cyc.size() > 0) ? w_cyc[w_cyc.size() - 1] : -100;
      checks++; if (busy_cnt - b0 !== 8 + CHK_CYC) begin errors++; $display("FAIL basic_busy_cycles got=%0d want=%0d", busy_cnt - b0, 8 + CHK_CYC); end
      checks++; if (last_done_cyc !== ld + 1 + CHK_CYC) begin errors++; $display("FAIL basic_done_timing got=%0d want=%0d", last_done_cyc, ld + 1 + CHK_CYC); end
    end
  endtask

  task automatic test_wrap();
    bit ok; int sc;
    int w0 = w_addr.size();
    make_tx(2); add_cks();
    drive_load(8'hFF, 9'd2, 0, ok, sc);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout got=no_done want=done"); end
    checks++; if (w_addr.size() - w0 !== 2) begin errors++; $display("FAIL wrap_nwrites got=%0d want=2", w_addr.size() - w0); end
    for (int w = 0; w < 2; w++) begin
      logic [7:0]  ga = (w0 + w < w_addr.size()) ? w_addr[w0 + w] : 8'hxx;
      logic [23:0] gd = (w0 + w < w_data.size()) ? w_data[w0 + w] : 24'hxxxxxx;
      checks++; if (ga !== model_addr(8'hFF, w)) begin errors++; $display("FAIL wrap_addr%0d got=%h want=%h", w, ga, model_addr(8'hFF, w)); end
      checks++; if (gd !== model_word(w)) begin errors++; $display("FAIL wrap_data%0d got=%h want=%h", w, gd, model_word(w)); end
    end
  endtask

  task automatic test_zero_count();
    bit ok; int sc;
    int w0 = w_addr.size(), b0 = busy_cnt, d0 = done_cnt;
    tx.delete();
    drive_load(8'h33, 9'd0, 0, ok, sc);
    checks++; if (!ok) begin errors++; $display("FAIL zero_timeout got=no_done want=done"); end
    checks++; if (w_addr.size() !== w0) begin errors++; $display("FAIL zero_writes got=%0d want=0", w_addr.size() - w0); end
    checks++; if (busy_cnt !== b0) begin errors++; $display("FAIL zero_busy got=%0d want=0", busy_cnt - b0); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL zero_done_pulses got=%0d want=1", done_cnt - d0); end
    checks++; if (last_done_cyc !== sc + 1) begin errors++; $display("FAIL zero_done_timing got=%0d want=%0d", last_done_cyc, sc + 1); end
  endtask

  task automatic test_abort();
    bit ok; int sc;
    int w0, d0;
    w0 = w_addr.size(); d0 = done_cnt;
    @(negedge clk); start = 1'b1; base_addr = 8'h40; word_count = 9'd1;
    @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = 8'h11;
    @(negedge clk); in_data = 8'h22;
    @(negedge clk); in_data = 8'h33; abort = 1'b1;  // abort beats the third byte
    @(negedge clk); abort = 1'b0; in_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle_busy got=%b want=0", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL abort_idle_ready got=%b want=0", in_ready); end
    repeat (4) @(negedge clk);
    checks++; if (w_addr.size() !== w0) begin errors++; $display("FAIL abort_writes got=%0d want=0", w_addr.size() - w0); end
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL abort_done got=%0d want=0", done_cnt - d0); end
    tx = '{8'h7A, 8'h00, 8'h99};
    add_cks();
    drive_load(8'h40, 9'd1, 0, ok, sc);
    checks++; if (!ok) begin errors++; $display("FAIL abort_reload_timeout got=no_done want=done"); end
    checks++; if (w_data.size() - w0 !== 1 || w_data[w_data.size() - 1] !== 24'h7A0099 || w_addr[w_addr.size() - 1] !== 8'h40)
      begin errors++; $display("FAIL abort_reload got=%0d writes, last=%h@%h want=1 write 7a0099@40",
                               w_data.size() - w0, w_data[w_data.size() - 1], w_addr[w_addr.size() - 1]); end
  endtask

  task automatic test_reset_midload();
    int w0 = w_addr.size(), d0 = done_cnt;
    @(negedge clk); start = 1'b1; base_addr = 8'h20; word_count = 9'd2;
    @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = 8'hA1;
    @(negedge clk); in_data = 8'hA2;
    @(negedge clk); in_data = 8'hA3; rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; in_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    checks++; if (w_addr.size() !== w0) begin errors++; $display("FAIL rstmid_writes got=%0d want=0", w_addr.size() - w0); end
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL rstmid_done got=%0d want=0", done_cnt - d0); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 5; it++) begin
      bit ok; int sc;
      int w0 = w_addr.size(), r0 = rdy_in_write;
      logic [7:0] base = 8'($urandom);
      int nw = $urandom_range(1, 5);
      make_tx(nw); add_cks();
      drive_load(base, 9'(nw), 2, ok, sc);
      checks++; if (!ok) begin errors++; $display("FAIL rand%0d_timeout got=no_done want=done", it); end
      checks++; if (w_addr.size() - w0 !== nw) begin errors++; $display("FAIL rand%0d_nwrites got=%0d want=%0d", it, w_addr.size() - w0, nw); end
      for (int w = 0; w < nw; w++) begin
        logic [7:0]  ga = (w0 + w < w_addr.size()) ? w_addr[w0 + w] : 8'hxx;
        logic [23:0] gd = (w0 + w < w_data.size()) ? w_data[w0 + w] : 24'hxxxxxx;
        checks++; if (ga !== model_addr(base, w) || gd !== model_word(w))
          begin errors++; $display("FAIL rand%0d_word%0d got=%h@%h want=%h@%h", it, w, gd, ga, model_word(w), model_addr(base, w)); end
      end
      checks++; if (rdy_in_write !== r0) begin errors++; $display("FAIL rand%0d_ready_in_write got=%0d want=0", it, rdy_in_write - r0); end
    end
    checks++; if (hold_bad !== 0) begin errors++; $display("FAIL cpu_hold_eq_busy got=%0d differing cycles want=0", hold_bad); end
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    bit ok; int sc;
    tx = '{8'hAA, 8'hBB, 8'hCC, 8'h31};
    drive_load(8'h00, 9'd1, 0, ok, sc);
    checks++; if (!ok || err !== 1'b0) begin errors++; $display("FAIL cks_good got=ok%b err%b want=ok1 err0", ok, err); end
    tx = '{8'hAA, 8'hBB, 8'hCC, 8'h30};
    drive_load(8'h00, 9'd1, 0, ok, sc);
    checks++; if (!ok || err !== 1'b1) begin errors++; $display("FAIL cks_bad got=ok%b err%b want=ok1 err1", ok, err); end
    repeat (6) @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL cks_sticky got=%b want=1", err); end
    @(negedge clk); start = 1'b1; base_addr = 8'h00; word_count = 9'd1;
    @(negedge clk); start = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL cks_clear_on_start got=%b want=0", err); end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic(0);
    test_basic(1);
    test_wrap();
    test_zero_count();
    test_abort();
    test_reset_midload();
    test_random();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
